hilo_mdu_ctrl: RTL and testbench

//  Sequences the shared iterative multiply/divide engines for the EXE stage and owns the HI/LO registers.
//  - Accepts one MULT/DIV request at a time from EXE.
//  - Holds operands and starts the correct engine, then waits for its completion handshake.
//  - Commits the result to HI/LO.
//  - Stalls EXE while busy. Flush on exception cancels the operation.

---
 rtl/hilo_mdu_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_hilo_mdu_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO owner and sequencer for the shared iterative multiply/divide engines.
// One MULT/DIV in flight; EXE is stalled until the result commits, a flush cancels it.
module hilo_mdu_ctrl #(
  parameter int TIMEOUT = 40
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_EXE_valid,
  input  logic        i_req_mult,
  input  logic        i_req_div,
  input  logic        i_op_signed,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  input  logic        i_mthi,
  input  logic        i_mtlo,
  input  logic        i_mf_req,
  input  logic        i_flush,
  output logic        o_mult_begin,
  output logic        o_div_begin,
  output logic [31:0] o_eng_op1,
  output logic [31:0] o_eng_op2,
  output logic        o_eng_signed,
  input  logic [63:0] i_product,
  input  logic        i_mult_end,
  input  logic [31:0] i_quotient,
  input  logic [31:0] i_remainder,
  input  logic        i_div_end,
  output logic        o_busy,
  output logic        o_md_done,
  output logic        o_EXE_stall,
  output logic        o_md_err,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_RUN,
    S_DIV_RUN,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_mult_begin;
  logic          r_div_begin;
  logic          r_busy;
  logic          r_md_done;
  logic          r_md_err;
  logic [31:0]   r_eng_op1;
  logic [31:0]   r_eng_op2;
  logic          r_eng_signed;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;

  logic          w_go;
  logic          w_acc_mul;
  logic          w_acc_div;
  logic          w_div_zero;
  logic          w_timeout;
  logic [CW-1:0] w_cnt_inc;

  // MULT wins over DIV when both decode bits are set
  assign w_go       = i_EXE_valid & ~i_flush;
  assign w_acc_mul  = w_go & i_req_mult;
  assign w_acc_div  = w_go & i_req_div & ~i_req_mult & (i_op2 != 32'd0);
  assign w_div_zero = w_go & i_req_div & ~i_req_mult & (i_op2 == 32'd0);
  assign w_timeout  = (r_cnt == CW'(TIMEOUT - 1));
  assign w_cnt_inc  = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_mult_begin <= 1'b0;
      r_div_begin  <= 1'b0;
      r_busy       <= 1'b0;
      r_md_done    <= 1'b0;
      r_md_err     <= 1'b0;
      r_eng_op1    <= '0;
      r_eng_op2    <= '0;
      r_eng_signed <= 1'b0;
      r_hi         <= '0;
      r_lo         <= '0;
    end else begin
      r_md_done <= 1'b0;
      r_md_err  <= 1'b0;
      if (i_flush) begin
        // cancel wins over any same-cycle end or move-to write
        r_state      <= S_IDLE;
        r_cnt        <= '0;
        r_mult_begin <= 1'b0;
        r_div_begin  <= 1'b0;
        r_busy       <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_acc_mul || w_acc_div) begin
              r_state      <= w_acc_mul ? S_MUL_RUN : S_DIV_RUN;
              r_mult_begin <= w_acc_mul;
              r_div_begin  <= w_acc_div;
              r_busy       <= 1'b1;
              r_cnt        <= '0;
              r_eng_op1    <= i_op1;
              r_eng_op2    <= i_op2;
              r_eng_signed <= i_op_signed;
            end else if (w_div_zero) begin
              // divide by zero: complete immediately, HI/LO left alone
              r_state   <= S_DONE;
              r_busy    <= 1'b1;
              r_md_done <= 1'b1;
            end else begin
              if (i_EXE_valid && i_mthi) r_hi <= i_op1;
              if (i_EXE_valid && i_mtlo) r_lo <= i_op1;
            end
          end
          S_MUL_RUN: begin
            if (i_mult_end) begin
              r_hi         <= i_product[63:32];
              r_lo         <= i_product[31:0];
              r_state      <= S_DONE;
              r_mult_begin <= 1'b0;
              r_md_done    <= 1'b1;
              r_cnt        <= '0;
            end else if (w_timeout) begin
              r_state      <= S_IDLE;
              r_mult_begin <= 1'b0;
              r_busy       <= 1'b0;
              r_md_err     <= 1'b1;
              r_cnt        <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          S_DIV_RUN: begin
            if (i_div_end) begin
              r_lo        <= i_quotient;
              r_hi        <= i_remainder;
              r_state     <= S_DONE;
              r_div_begin <= 1'b0;
              r_md_done   <= 1'b1;
              r_cnt       <= '0;
            end else if (w_timeout) begin
              r_state     <= S_IDLE;
              r_div_begin <= 1'b0;
              r_busy      <= 1'b0;
              r_md_err    <= 1'b1;
              r_cnt       <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // the issuing instruction is released in its own DONE cycle
  assign o_EXE_stall = i_EXE_valid &
                       (((i_req_mult | i_req_div) & (r_state != S_DONE)) |
                        ((i_mthi | i_mtlo | i_mf_req) & r_busy));

  assign o_mult_begin = r_mult_begin;
  assign o_div_begin  = r_div_begin;
  assign o_eng_op1    = r_eng_op1;
  assign o_eng_op2    = r_eng_op2;
  assign o_eng_signed = r_eng_signed;
  assign o_busy       = r_busy;
  assign o_md_done    = r_md_done;
  assign o_md_err     = r_md_err;
  assign o_hi         = r_hi;
  assign o_lo         = r_lo;

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Directed bench for hilo_mdu_ctrl; the bench plays the engines and scoreboards HI/LO commits.
module tb_hilo_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset, exe_valid, req_mult, req_div, op_signed;
  logic [31:0] op1, op2;
  logic        mthi, mtlo, mf_req, flush;
  logic [63:0] product;
  logic        mult_end, div_end;
  logic [31:0] quotient, remainder;
  logic        mult_begin, div_begin, eng_signed, busy, md_done, exe_stall, md_err;
  logic [31:0] eng_op1, eng_op2, hi, lo;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  hilo_mdu_ctrl #(.TIMEOUT(40)) dut (
    .i_clk(clk), .i_reset(reset), .i_EXE_valid(exe_valid),
    .i_req_mult(req_mult), .i_req_div(req_div), .i_op_signed(op_signed),
    .i_op1(op1), .i_op2(op2), .i_mthi(mthi), .i_mtlo(mtlo),
    .i_mf_req(mf_req), .i_flush(flush),
    .o_mult_begin(mult_begin), .o_div_begin(div_begin),
    .o_eng_op1(eng_op1), .o_eng_op2(eng_op2), .o_eng_signed(eng_signed),
    .i_product(product), .i_mult_end(mult_end),
    .i_quotient(quotient), .i_remainder(remainder), .i_div_end(div_end),
    .o_busy(busy), .o_md_done(md_done), .o_EXE_stall(exe_stall),
    .o_md_err(md_err), .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    chk({tag, "_md_done"}, 64'(md_done), 64'd1);
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
      chk({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
    end
  endtask

  task automatic idle_inputs();
    exe_valid = 0; req_mult = 0; req_div = 0; mthi = 0; mtlo = 0;
    mf_req = 0; flush = 0; mult_end = 0; div_end = 0;
  endtask

  initial begin
    int     bad;
    longint a, b;
    reset = 1; op_signed = 0; op1 = 0; op2 = 0;
    product = 0; quotient = 0; remainder = 0;
    idle_inputs();
    tick(); tick();
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_ctl", {60'd0, busy, md_done, md_err, exe_stall}, 64'd0);
    chk("rst_begin", {62'd0, mult_begin, div_begin}, 64'd0);
    chk("rst_eng", {eng_signed, eng_op1, eng_op2}, 64'd0);
    reset = 0;
    tick();

    // 1: signed MULT -2 * 3, end in 33rd RUN cycle
    exe_valid = 1; req_mult = 1; op_signed = 1; op1 = 32'hFFFF_FFFE; op2 = 32'd3;
    #1 chk("t1_stall_idle", 64'(exe_stall), 64'd1);
    sb.push_back('{"t1_mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA});
    tick();
    chk("t1_mult_begin", 64'(mult_begin), 64'd1);
    chk("t1_eng", {31'd0, eng_signed, eng_op1}, {31'd0, 1'b1, 32'hFFFF_FFFE});
    chk("t1_eng_op2", 64'(eng_op2), 64'd3);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (!mult_begin || !exe_stall || md_done) bad++;
      tick();
    end
    chk("t1_hold", 64'(bad), 64'd0);
    a = longint'($signed(op1)); b = longint'($signed(op2));
    product = 64'(a * b); mult_end = 1;
    tick();
    sb_check("t1");
    chk("t1_begin_drop", 64'(mult_begin), 64'd0);
    chk("t1_stall_done", 64'(exe_stall), 64'd0);
    idle_inputs();
    tick();
    chk("t1_idle", {62'd0, busy, md_done}, 64'd0);

    // 2: DIVU 100 / 7
    exe_valid = 1; req_div = 1; op_signed = 0; op1 = 32'd100; op2 = 32'd7;
    sb.push_back('{"t2_divu", 32'd2, 32'd14});
    tick();
    chk("t2_begins", {62'd0, mult_begin, div_begin}, 64'd1);
    chk("t2_eng_signed", 64'(eng_signed), 64'd0);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (!div_begin || !exe_stall) bad++;
      tick();
    end
    chk("t2_hold", 64'(bad), 64'd0);
    quotient = 32'd100 / 32'd7; remainder = 32'd100 % 32'd7; div_end = 1;
    tick();
    sb_check("t2");
    chk("t2_begin_drop", 64'(div_begin), 64'd0);
    idle_inputs();
    tick();

    // 3: DIV by zero completes next cycle, HI/LO kept
    exe_valid = 1; req_div = 1; op_signed = 1; op1 = 32'd5; op2 = 32'd0;
    sb.push_back('{"t3_div0", 32'd2, 32'd14});
    tick();
    sb_check("t3");
    chk("t3_no_begin", {62'd0, mult_begin, div_begin}, 64'd0);
    chk("t3_busy", 64'(busy), 64'd1);
    idle_inputs();
    tick();
    chk("t3_idle", {62'd0, busy, md_done}, 64'd0);

    // 4: flush in 10th RUN cycle, with a same-cycle end that must be ignored
    exe_valid = 1; req_mult = 1; op_signed = 0; op1 = 32'd7; op2 = 32'd9;
    tick();
    repeat (9) tick();
    chk("t4_running", 64'(mult_begin), 64'd1);
    idle_inputs();
    flush = 1; mult_end = 1; product = 64'd63;
    tick();
    chk("t4_flush_ctl", {61'd0, mult_begin, busy, md_done}, 64'd0);
    chk("t4_hilo", {hi, lo}, {32'd2, 32'd14});
    idle_inputs();
    tick();
    chk("t4_no_done", 64'(md_done), 64'd0);

    // 5: MF stalls behind a DIV; MTHI/MTLO in IDLE
    exe_valid = 1; req_div = 1; op_signed = 1; op1 = 32'd1000; op2 = 32'd10;
    sb.push_back('{"t5_div", 32'd0, 32'd100});
    tick();
    req_div = 0; mf_req = 1;
    #1 chk("t5_mf_stall_run", 64'(exe_stall), 64'd1);
    repeat (5) tick();
    chk("t5_mf_stall_run2", 64'(exe_stall), 64'd1);
    quotient = 32'd100; remainder = 32'd0; div_end = 1;
    tick();
    sb_check("t5");
    chk("t5_mf_stall_done", 64'(exe_stall), 64'd1);
    div_end = 0;
    tick();
    chk("t5_mf_release", {62'd0, busy, exe_stall}, 64'd0);
    mf_req = 0; mthi = 1; op1 = 32'h1234;
    #1 chk("t5_mthi_nostall", 64'(exe_stall), 64'd0);
    tick();
    mthi = 0;
    chk("t5_mthi", {hi, lo}, {32'h1234, 32'd100});
    mtlo = 1; flush = 1; op1 = 32'hBEEF;
    tick();
    chk("t5_mtlo_flushed", 64'(lo), 64'd100);
    flush = 0; op1 = 32'h55;
    tick();
    mtlo = 0;
    chk("t5_mtlo", {hi, lo}, {32'h1234, 32'h55});
    idle_inputs();
    tick();

    // 6: engine never ends -> abort after 40 RUN cycles
    exe_valid = 1; req_mult = 1; op1 = 32'd3; op2 = 32'd4;
    tick();
    idle_inputs();
    repeat (39) tick();
    chk("t6_last_run", {62'd0, busy, md_err}, 64'd2);
    tick();
    chk("t6_err", {60'd0, md_err, busy, mult_begin, md_done}, 64'd8);
    chk("t6_hilo", {hi, lo}, {32'h1234, 32'h55});
    tick();
    chk("t6_err_pulse", 64'(md_err), 64'd0);

    // 7: reset mid-operation clears everything
    exe_valid = 1; req_div = 1; op1 = 32'd50; op2 = 32'd5;
    tick();
    idle_inputs();
    repeat (3) tick();
    reset = 1;
    tick();
    chk("t7_rst_hilo", {hi, lo}, 64'd0);
    chk("t7_rst_ctl", {61'd0, busy, div_begin, eng_signed}, 64'd0);
    chk("t7_rst_eng", 64'(eng_op1), 64'd0);
    reset = 0;
    tick();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
